// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester round-robin front end for one shared alu,
//               with a registered, id-tagged response channel.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu #(
  parameter int n_alu = 4
) (
  input  logic [3:0]       op,
  input  logic [n_alu-1:0] a,
  input  logic [n_alu-1:0] b,
  output logic [n_alu-1:0] dout,
  output logic             err,
  output logic             zero,
  output logic             of
);

  always_comb begin
    dout = '0;
    err  = 1'b0;
    zero = 1'b0;
    of   = 1'b0;
    case (op)
      4'd0: {of, dout} = {1'b0, a} + {1'b0, b};
      4'd1: begin
        dout = a - b;
        of   = (a < b);
      end
      4'd2: dout = a << b;
      4'd3: dout = a >> b;
      4'd4: zero = (a == b);
      4'd5: zero = (a > b);
      4'd6: zero = (a < b);
      default: begin
        err  = 1'b1;
        dout = '1;
      end
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int N_ALU = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [N_ALU-1:0] req0_a,
  input  logic [N_ALU-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [N_ALU-1:0] req1_a,
  input  logic [N_ALU-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N_ALU-1:0] rsp_dout,
  output logic             rsp_err,
  output logic             rsp_zero,
  output logic             rsp_of,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             grant;
  logic             accept;
  logic [3:0]       op_q;
  logic [N_ALU-1:0] a_q;
  logic [N_ALU-1:0] b_q;
  logic             id_q;
  logic [N_ALU-1:0] alu_dout;
  logic             alu_err;
  logic             alu_zero;
  logic             alu_of;
  logic             is_cmp;

  // Contention goes to prio; otherwise whichever requester is valid.
  assign grant      = (req0_valid && req1_valid) ? prio : req1_valid;
  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign busy       = (state != IDLE);
  assign is_cmp     = (op_q == 4'd4) || (op_q == 4'd5) || (op_q == 4'd6);

  alu #(.n_alu(N_ALU)) u_alu (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .dout (alu_dout),
    .err  (alu_err),
    .zero (alu_zero),
    .of   (alu_of)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_dout  <= '0;
      rsp_err   <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_of    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_dout  <= is_cmp ? '0 : alu_dout;
        rsp_err   <= alu_err;
        rsp_zero  <= alu_zero;
        rsp_of    <= alu_of;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        prio      <= ~rsp_id;
      end
    end
  end

  // Command holding registers need no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= grant ? req1_op : req0_op;
      a_q  <= grant ? req1_a  : req0_a;
      b_q  <= grant ? req1_b  : req0_b;
      id_q <= grant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N_ALU=4): directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
`default_nettype none

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, rsp_zero, rsp_of, busy;
  logic [3:0] rsp_dout;

  int   checks = 0;
  int   errors = 0;
  logic m_prio = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.N_ALU(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .rsp_err(rsp_err), .rsp_zero(rsp_zero), .rsp_of(rsp_of), .busy(busy)
  );

  // Reference alu from plain integer arithmetic on 4-bit unsigned values.
  task automatic ref_alu(input int op, input int a, input int b,
                         output logic [3:0] d, output logic e, output logic z, output logic o);
    int s;
    d = 4'd0; e = 1'b0; z = 1'b0; o = 1'b0;
    case (op)
      0: begin s = a + b; d = 4'(s % 16); o = (s > 15); end
      1: begin s = a - b; d = 4'((s + 16) % 16); o = (s < 0); end
      2: d = 4'((a << b) % 16);
      3: d = 4'(a >> b);
      4: z = (a == b);
      5: z = (a > b);
      6: z = (a < b);
      default: begin e = 1'b1; d = 4'd15; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from an IDLE cycle; hold = cycles rsp_ready stays low in RESP.
  task automatic run_cmd(input logic v0, input logic v1,
                         input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                         input int hold, input logic keep);
    logic w;
    logic [3:0] ed;
    logic ee, ez, ef;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0;
    #1;
    w = (v0 && v1) ? m_prio : v1;
    if (w) ref_alu(int'(op1), int'(a1), int'(b1), ed, ee, ez, ef);
    else   ref_alu(int'(op0), int'(a0), int'(b0), ed, ee, ez, ef);
    checks++; if (req0_ready !== (v0 && !w)) begin errors++; $display("FAIL req0_ready got %b want %b", req0_ready, v0 && !w); end
    checks++; if (req1_ready !== (v1 && w)) begin errors++; $display("FAIL req1_ready got %b want %b", req1_ready, v1 && w); end
    step();
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    req0_op = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_op = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
    #1;
    checks++; if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b1000) begin errors++; $display("FAIL exec_state busy/rsp_valid/readys got %b want 1000", {busy, rsp_valid, req0_ready, req1_ready}); end
    step();
    for (int i = 0; i <= hold; i++) begin
      checks++; if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100) begin errors++; $display("FAIL resp_ctl rsp_valid/busy/readys got %b want 1100", {rsp_valid, busy, req0_ready, req1_ready}); end
      checks++; if (rsp_id !== w) begin errors++; $display("FAIL rsp_id got %b want %b", rsp_id, w); end
      checks++; if ({rsp_dout, rsp_err, rsp_zero, rsp_of} !== {ed, ee, ez, ef}) begin errors++; $display("FAIL rsp_data dout/err/zero/of got %h/%b/%b/%b want %h/%b/%b/%b", rsp_dout, rsp_err, rsp_zero, rsp_of, ed, ee, ez, ef); end
      if (i < hold) begin
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        step();
      end
    end
    rsp_ready = 1'b1;
    req0_valid = keep; req1_valid = keep;
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL release rsp_valid/busy got %b want 00", {rsp_valid, busy}); end
    m_prio = ~w;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) step();
    checks++; if ({rsp_valid, rsp_id, rsp_dout, rsp_err, rsp_zero, rsp_of, busy} !== 10'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", {rsp_valid, rsp_id, rsp_dout, rsp_err, rsp_zero, rsp_of, busy}); end
    rst = 1'b0;
    step(); step();
    checks++; if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin errors++; $display("FAIL idle_no_valid got %b want 0000", {busy, rsp_valid, req0_ready, req1_ready}); end
    m_prio = 1'b0;
  endtask

  task automatic test_basic();
    run_cmd(1, 0, 4'd0, 4'd9, 4'd8, 4'd0, 4'd0, 4'd0, 0, 0);
    run_cmd(0, 1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 4'd5, 0, 0);
    run_cmd(0, 1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd7, 1, 0);
    run_cmd(1, 0, 4'b1010, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 0, 0);
    // Spec-literal anchors independent of the model.
    run_cmd(1, 0, 4'd2, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 0, 0);
    checks++; if (rsp_dout !== 4'hC) begin errors++; $display("FAIL shl_literal got %h want c", rsp_dout); end
  endtask

  task automatic test_alternation();
    // Both held valid: strict alternation starting from the current favoured side.
    for (int i = 0; i < 4; i++)
      run_cmd(1, 1, 4'd0, 4'(i), 4'd1, 4'd1, 4'd9, 4'(i), 0, (i < 3));
  endtask

  task automatic test_backpressure();
    run_cmd(1, 1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd9, 4'd2, 5, 0);
  endtask

  task automatic test_reset_in_exec();
    if (m_prio == 1'b0) run_cmd(1, 0, 4'd3, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 0, 0);
    req0_valid = 1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 0;
    step();
    req0_valid = 0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_exec busy/rsp_valid got %b want 00", {busy, rsp_valid}); end
    step(); step();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_no_rsp busy/rsp_valid got %b want 00", {busy, rsp_valid}); end
    m_prio = 1'b0;
    run_cmd(1, 1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 0, 0);
  endtask

  task automatic test_random();
    logic v0, v1;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1'b1;
      run_cmd(v0, v1, 4'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
